// File: rtl/div_req_ctrl.sv
// Request/response controller for the signed divide unit. Operands are held on the divider interface while it works.
// Latency: response valid 2 cycles after accept with a single-cycle divider. Backpressure: a held response blocks new requests.
module div_req_ctrl #(
    parameter int length  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [length-1:0] req_a,
    input  logic [length-1:0] req_b,
    input  logic              req_is_div,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [length-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_dbz,
    output logic              timeout_err,
    output logic              busy,
    output logic [length-1:0] oper_a,
    output logic [length-1:0] oper_b,
    output logic              fuct3,
    output logic              enable_div,
    input  logic [length-1:0] div_o,
    input  logic              div_finish,
    input  logic              divided_by_zero
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [7:0]        cnt;
    logic [length-1:0] op_a_q, op_b_q;
    logic              op_div_q;
    logic [4:0]        rd_q;
    logic              accept;
    logic              cnt_expired;

    // Control outputs decode registered state only; divider inputs never reach them.
    assign req_ready   = rst_n && !flush && (state == IDLE);
    assign accept      = req_valid && req_ready;
    assign busy        = (state != IDLE);
    assign enable_div  = (state == BUSY);
    assign rsp_valid   = (state == RESP);
    assign cnt_expired = (cnt == CNT_LAST);

    assign oper_a = op_a_q;
    assign oper_b = op_b_q;
    assign fuct3  = op_div_q;
    assign rsp_rd = rd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (div_finish || cnt_expired) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_div_q    <= 1'b0;
            rd_q        <= '0;
            rsp_data    <= '0;
            rsp_dbz     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                op_a_q   <= req_a;
                op_b_q   <= req_b;
                op_div_q <= req_is_div;
                rd_q     <= req_rd;
                cnt      <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 8'd1;
            end

            // A finishing divider wins over the watchdog in the same cycle.
            if (state == BUSY && !flush) begin
                if (div_finish) begin
                    timeout_err <= 1'b0;
                    if (divided_by_zero) begin
                        rsp_data <= op_div_q ? '1 : op_a_q;
                        rsp_dbz  <= 1'b1;
                    end else begin
                        rsp_data <= div_o;
                        rsp_dbz  <= 1'b0;
                    end
                end else if (cnt_expired) begin
                    rsp_data    <= '0;
                    rsp_dbz     <= 1'b0;
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_req_ctrl.sv
// Bench for div_req_ctrl: a behavioural divider with programmable latency drives the DUT,
// and every response is compared against a model built from the RV32M result rules.
module tb_div_req_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n, flush, req_valid, req_ready, req_is_div;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_rd;
    logic        rsp_valid, rsp_ready, rsp_dbz, timeout_err, busy;
    logic [31:0] rsp_data, oper_a, oper_b, div_o;
    logic [4:0]  rsp_rd;
    logic        fuct3, enable_div, div_finish, divided_by_zero;

    int errors = 0;
    int checks = 0;
    int ecnt   = 0;
    int dv_lat = 0;

    always #5 clk = ~clk;

    div_req_ctrl #(.length(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_is_div(req_is_div), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_dbz(rsp_dbz), .timeout_err(timeout_err), .busy(busy),
        .oper_a(oper_a), .oper_b(oper_b), .fuct3(fuct3), .enable_div(enable_div),
        .div_o(div_o), .div_finish(div_finish), .divided_by_zero(divided_by_zero)
    );

    // Truncating signed divide in 64-bit arithmetic; -2^31 / -1 wraps to 0x80000000 with remainder 0.
    function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b, input logic d);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (d) return 32'(sa / sb);
        return 32'(sa % sb);
    endfunction

    // Divider: finishes after dv_lat extra cycles of enable; garbage quotient on divide by zero.
    always @(posedge clk) ecnt <= enable_div ? ecnt + 1 : 0;
    assign div_finish      = enable_div && (ecnt == dv_lat);
    assign divided_by_zero = div_finish && (oper_b == 32'd0);
    assign div_o           = (oper_b == 32'd0) ? 32'h0BAD0BAD : sdiv(oper_a, oper_b, fuct3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic d, input int lat,
                                  output logic [31:0] data, output logic dbz, output logic tmo, output int cyc);
        if (lat >= TIMEOUT) begin
            data = 32'd0; dbz = 1'b0; tmo = 1'b1; cyc = TIMEOUT;
        end else begin
            cyc = lat + 1;
            tmo = 1'b0;
            if (b == 32'd0) begin
                dbz  = 1'b1;
                data = d ? 32'hFFFF_FFFF : a;
            end else begin
                dbz  = 1'b0;
                data = sdiv(a, b, d);
            end
        end
    endfunction

    task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic d,
                          input logic [4:0] rd, input int lat, input int hold);
        logic [31:0] edata;
        logic        edbz, etmo;
        int          ecyc, cyc, en;
        model(a, b, d, lat, edata, edbz, etmo, ecyc);
        dv_lat = lat;
        req_a = a; req_b = b; req_is_div = d; req_rd = rd; req_valid = 1'b1;
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_rd = 5'($urandom);
        #1;
        chk("enable_first", 32'(enable_div), 32'd1);
        chk("oper_a", oper_a, a);
        chk("oper_b", oper_b, b);
        chk("fuct3", 32'(fuct3), 32'(d));
        cyc = 0; en = 0;
        while (!rsp_valid && cyc < 400) begin
            en += int'(enable_div);
            tick();
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(ecyc));
        chk("enable_cycles", 32'(en), 32'(ecyc));
        chk("rsp_data", rsp_data, edata);
        chk("rsp_rd", 32'(rsp_rd), 32'(rd));
        chk("rsp_dbz", 32'(rsp_dbz), 32'(edbz));
        chk("timeout_err", 32'(timeout_err), 32'(etmo));
        chk("enable_resp", 32'(enable_div), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", rsp_data, edata);
            chk("hold_rd", 32'(rsp_rd), 32'(rd));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_is_div = 1'b0; req_rd = '0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        tick(); tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_enable", 32'(enable_div), 32'd0);
        chk("reset_oper_a", oper_a, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", 32'(req_ready), 32'd1);

        // Directed: signed div/rem, divide by zero, backpressure, watchdog, overflow.
        do_txn(-32'sd20, 32'sd6, 1'b1, 5'd5, 0, 0);
        do_txn(-32'sd20, 32'sd6, 1'b0, 5'd6, 0, 0);
        do_txn(32'sd20, -32'sd6, 1'b0, 5'd7, 0, 0);
        do_txn(32'd7, 32'd0, 1'b1, 5'd8, 0, 0);
        do_txn(32'd7, 32'd0, 1'b0, 5'd9, 0, 0);
        do_txn(32'd100, 32'd7, 1'b1, 5'd10, 2, 5);
        do_txn(32'd5, 32'd3, 1'b1, 5'd11, 300, 0);
        do_txn(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd12, 0, 1);
        do_txn(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd13, 0, 0);
        do_txn(32'd9, 32'd2, 1'b0, 5'd14, TIMEOUT - 1, 0);

        // Flush while the divider is working.
        dv_lat = 100;
        req_a = 32'd50; req_b = 32'd5; req_is_div = 1'b1; req_rd = 5'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_enable", 32'(enable_div), 32'd0);
        chk("flush_valid", 32'(rsp_valid), 32'd0);
        chk("flush_ready", 32'(req_ready), 32'd1);
        repeat (20) tick();
        chk("flush_no_rsp", 32'(rsp_valid), 32'd0);

        // Flush blocks acceptance in IDLE.
        flush = 1'b1; req_valid = 1'b1;
        #1;
        chk("flush_idle_ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        #1;
        chk("flush_idle_busy", 32'(busy), 32'd0);

        // Reset while a response is pending.
        dv_lat = 0;
        req_a = 32'd123; req_b = 32'd7; req_is_div = 1'b1; req_rd = 5'd9; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_rd", 32'(rsp_rd), 32'd0);
        chk("rst_dbz_tmo", 32'({rsp_dbz, timeout_err, fuct3}), 32'd0);
        chk("rst_opers", oper_a | oper_b, 32'd0);
        rst_n = 1'b1;
        tick();

        // Random traffic, including zero divisors, overflow operands and watchdog aborts.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            int          sel;
            a   = $urandom;
            b   = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 9));
            do_txn(a, b, 1'($urandom), 5'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
